cbm2_keyboard: RTL and testbench

- Keyboard matrix emulator sitting downstream of the 6525 TPI that scans the CBM-II keyboard.
- Consumes the TPI column-select outputs (PA/PB) and produces the row-sense inputs fed back to TPI port C bits 5:0.
- Key state comes from the MiSTer HPS PS/2 key word. Events pass through a registered lookup pipeline into a 16x6 key-state matrix.

---
 rtl/cbm2_keyboard_if.sv | 25 ++
 rtl/cbm2_keyboard.sv | 223 ++++++++++++++++++++++
 tb/tb_cbm2_keyboard.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cbm2_keyboard_if.sv
// Keyboard emulator link: HPS key word and TPI column selects in, row sense and
// change strobe out.
interface cbm2_keyboard_if;
    logic [10:0] ps2_key;
    logic        release_all;
    logic [15:0] col_n;
    logic [5:0]  row_n;
    logic        key_evt;

    modport master (
        output ps2_key,
        output release_all,
        output col_n,
        input  row_n,
        input  key_evt
    );

    modport slave (
        input  ps2_key,
        input  release_all,
        input  col_n,
        output row_n,
        output key_evt
    );
endinterface

// File: rtl/cbm2_keyboard.sv
// CBM-II keyboard matrix emulator: PS/2 key events are mapped through a
// registered lookup into a 16x6 key matrix that the TPI scans via col_n/row_n.
module cbm2_keyboard (
    input  logic             clk,
    input  logic             reset,
    cbm2_keyboard_if.slave   kb
);
    localparam int unsigned COLS     = 16;
    localparam int unsigned ROWS     = 6;
    localparam int unsigned COL_W    = 4;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned SHIFT_C  = 8;
    localparam int unsigned SHIFT_R  = 5;

    typedef struct packed {
        logic             hit;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic             lsh;
        logic             rsh;
    } map_t;

    // Mapped cell at column c, row r.
    function automatic map_t at(input int unsigned c, input int unsigned r);
        map_t m;
        m     = '0;
        m.hit = 1'b1;
        m.col = COL_W'(c);
        m.row = ROW_W'(r);
        return m;
    endfunction

    // PS/2 set-2 scancode (with E0 prefix flag) to CBM-II matrix position.
    function automatic map_t lookup(input logic ext, input logic [7:0] code);
        map_t m;
        m = '0;
        case ({ext, code})
            9'h005: m = at(0, 0);    // F1
            9'h006: m = at(1, 0);    // F2
            9'h004: m = at(2, 0);    // F3
            9'h00C: m = at(3, 0);    // F4
            9'h003: m = at(4, 0);    // F5
            9'h00B: m = at(5, 0);    // F6
            9'h083: m = at(6, 0);    // F7
            9'h00A: m = at(7, 0);    // F8
            9'h001: m = at(8, 0);    // F9
            9'h009: m = at(9, 0);    // F10
            9'h172: m = at(10, 0);   // cursor down
            9'h16B: m = at(11, 0);   // cursor left
            9'h174: m = at(12, 0);   // cursor right
            9'h16C: m = at(13, 0);   // home
            9'h075: m = at(14, 0);   // keypad 8
            9'h077: m = at(15, 0);   // num lock
            9'h076: m = at(0, 1);    // esc
            9'h016: m = at(1, 1);
            9'h01E: m = at(2, 1);
            9'h026: m = at(3, 1);
            9'h025: m = at(4, 1);
            9'h02E: m = at(5, 1);
            9'h036: m = at(6, 1);
            9'h03D: m = at(7, 1);
            9'h03E: m = at(8, 1);
            9'h046: m = at(9, 1);
            9'h045: m = at(10, 1);
            9'h04E: m = at(11, 1);
            9'h055: m = at(12, 1);
            9'h066: m = at(13, 1);   // backspace
            9'h175: m = at(14, 1);   // cursor up
            9'h06C: m = at(15, 1);   // keypad 7
            9'h00D: m = at(0, 2);    // tab
            9'h015: m = at(1, 2);    // Q
            9'h01C: m = at(2, 2);    // A
            9'h01D: m = at(3, 2);    // W
            9'h024: m = at(4, 2);    // E
            9'h02D: m = at(5, 2);    // R
            9'h02C: m = at(6, 2);    // T
            9'h035: m = at(7, 2);    // Y
            9'h03C: m = at(8, 2);    // U
            9'h043: m = at(9, 2);    // I
            9'h044: m = at(10, 2);   // O
            9'h04D: m = at(11, 2);   // P
            9'h054: m = at(12, 2);   // [
            9'h05B: m = at(13, 2);   // ]
            9'h06B: m = at(14, 2);   // keypad 4
            9'h07D: m = at(15, 2);   // keypad 9
            9'h058: m = at(0, 3);    // caps lock
            9'h01B: m = at(1, 3);    // S
            9'h023: m = at(2, 3);    // D
            9'h02B: m = at(3, 3);    // F
            9'h034: m = at(4, 3);    // G
            9'h033: m = at(5, 3);    // H
            9'h03B: m = at(6, 3);    // J
            9'h042: m = at(7, 3);    // K
            9'h04B: m = at(8, 3);    // L
            9'h04C: m = at(9, 3);    // ;
            9'h052: m = at(10, 3);   // '
            9'h05D: m = at(11, 3);   // backslash
            9'h171: m = at(12, 3);   // delete
            9'h05A: m = at(13, 3);   // return
            9'h073: m = at(14, 3);   // keypad 5
            9'h074: m = at(15, 3);   // keypad 6
            9'h014: m = at(0, 4);    // ctrl
            9'h01A: m = at(1, 4);    // Z
            9'h022: m = at(2, 4);    // X
            9'h021: m = at(3, 4);    // C
            9'h02A: m = at(4, 4);    // V
            9'h032: m = at(5, 4);    // B
            9'h031: m = at(6, 4);    // N
            9'h03A: m = at(7, 4);    // M
            9'h041: m = at(8, 4);    // ,
            9'h049: m = at(9, 4);    // .
            9'h04A: m = at(10, 4);   // /
            9'h069: m = at(14, 4);   // keypad 1
            9'h072: m = at(15, 4);   // keypad 2
            9'h00E: m = at(0, 5);    // C= key
            9'h011: m = at(1, 5);    // alt
            9'h029: m = at(10, 5);   // space
            9'h07A: m = at(12, 5);   // keypad 3
            9'h15A: m = at(13, 5);   // keypad enter
            9'h070: m = at(14, 5);   // keypad 0
            9'h071: m = at(15, 5);   // keypad .
            9'h012: begin m = at(SHIFT_C, SHIFT_R); m.lsh = 1'b1; end
            9'h059: begin m = at(SHIFT_C, SHIFT_R); m.rsh = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    logic                       tog_q;
    logic                       s0_valid;
    logic                       s0_pressed;
    logic                       s0_ext;
    logic [7:0]                 s0_code;
    logic                       s1_valid;
    logic                       s1_pressed;
    map_t                       s1_map;
    logic [COLS-1:0][ROWS-1:0]  mat;
    logic                       lsh_q;
    logic                       rsh_q;
    logic [ROWS-1:0]            row_q;
    logic                       evt_q;

    logic [COLS-1:0][ROWS-1:0]  mat_n;
    logic [COLS-1:0][ROWS-1:0]  eff;
    logic                       lsh_n;
    logic                       rsh_n;
    logic                       evt_n;
    logic [ROWS-1:0]            sense;
    logic [ROWS-1:0]            row_next;

    // Stage 2: apply the looked-up event and flag an effective cell change.
    always_comb begin
        mat_n = mat;
        lsh_n = lsh_q;
        rsh_n = rsh_q;
        evt_n = 1'b0;
        if (s1_valid && s1_map.hit) begin
            if (s1_map.lsh || s1_map.rsh) begin
                if (s1_map.lsh) lsh_n = s1_pressed;
                if (s1_map.rsh) rsh_n = s1_pressed;
                evt_n = (lsh_q | rsh_q) != (lsh_n | rsh_n);
            end else begin
                mat_n[s1_map.col][s1_map.row] = s1_pressed;
                evt_n = mat[s1_map.col][s1_map.row] != s1_pressed;
            end
        end
    end

    // Shift cell is the OR of both holders so either shift keeps it down.
    always_comb begin
        eff                   = mat;
        eff[SHIFT_C][SHIFT_R] = mat[SHIFT_C][SHIFT_R] | lsh_q | rsh_q;
        sense                 = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!kb.col_n[c]) sense = sense | eff[c];
        end
        row_next = ~sense;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q      <= kb.ps2_key[10];
            s0_valid   <= 1'b0;
            s0_pressed <= 1'b0;
            s0_ext     <= 1'b0;
            s0_code    <= '0;
            s1_valid   <= 1'b0;
            s1_pressed <= 1'b0;
            s1_map     <= '0;
            mat        <= '0;
            lsh_q      <= 1'b0;
            rsh_q      <= 1'b0;
            row_q      <= '1;
            evt_q      <= 1'b0;
        end else begin
            tog_q      <= kb.ps2_key[10];
            row_q      <= row_next;
            s0_pressed <= kb.ps2_key[9];
            s0_ext     <= kb.ps2_key[8];
            s0_code    <= kb.ps2_key[7:0];
            s1_pressed <= s0_pressed;
            s1_map     <= lookup(s0_ext, s0_code);
            if (kb.release_all) begin
                s0_valid <= 1'b0;
                s1_valid <= 1'b0;
                mat      <= '0;
                lsh_q    <= 1'b0;
                rsh_q    <= 1'b0;
                evt_q    <= 1'b0;
            end else begin
                s0_valid <= kb.ps2_key[10] != tog_q;
                s1_valid <= s0_valid;
                mat      <= mat_n;
                lsh_q    <= lsh_n;
                rsh_q    <= rsh_n;
                evt_q    <= evt_n;
            end
        end
    end

    assign kb.row_n   = row_q;
    assign kb.key_evt = evt_q;
endmodule

// File: tb/tb_cbm2_keyboard.sv
// Directed bench for cbm2_keyboard: key events, column scans, shift holders,
// release_all and reset behaviour against hand-computed row_n values.
module tb_cbm2_keyboard;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   evts;

    cbm2_keyboard_if kb ();

    cbm2_keyboard dut (
        .clk   (clk),
        .reset (reset),
        .kb    (kb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n cycles (sampling at negedge) and count key_evt pulses seen.
    task automatic wait_cyc(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (kb.key_evt === 1'b1) cnt++;
        end
    endtask

    task automatic toggle_key(input logic p, input logic e, input logic [7:0] code);
        kb.ps2_key = {~kb.ps2_key[10], p, e, code};
    endtask

    // One key event followed by enough cycles for it to reach row_n.
    task automatic key(input logic p, input logic e, input logic [7:0] code, output int cnt);
        toggle_key(p, e, code);
        wait_cyc(4, cnt);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        kb.ps2_key     = 11'h000;
        kb.release_all = 1'b0;
        kb.col_n       = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_row_n", 16'(kb.row_n), 16'h003F);
        check("reset_evt", 16'(kb.key_evt), 16'h0000);

        // Press A: exact latency and one key_evt pulse.
        kb.col_n = 16'hFFFB;
        toggle_key(1'b1, 1'b0, 8'h1C);
        wait_cyc(2, evts);
        check("a_row_early", 16'(kb.row_n), 16'h003F);
        check("a_evt_early", 16'(evts), 16'd0);
        @(negedge clk);
        check("a_evt_pulse", 16'(kb.key_evt), 16'h0001);
        @(negedge clk);
        check("a_row_n", 16'(kb.row_n), 16'h003B);
        check("a_evt_done", 16'(kb.key_evt), 16'h0000);
        kb.col_n = 16'hFFFF;
        @(negedge clk);
        check("no_col_row_n", 16'(kb.row_n), 16'h003F);

        // A and space on two scanned columns, then release A.
        key(1'b1, 1'b0, 8'h29, evts);
        check("space_evt", 16'(evts), 16'd1);
        kb.col_n = 16'hFBFB;
        @(negedge clk);
        check("a_space_rows", 16'(kb.row_n), 16'h001B);
        key(1'b0, 1'b0, 8'h1C, evts);
        check("rel_a_evt", 16'(evts), 16'd1);
        check("rel_a_rows", 16'(kb.row_n), 16'h001F);
        key(1'b1, 1'b0, 8'h29, evts);
        check("repeat_make_evt", 16'(evts), 16'd0);
        key(1'b0, 1'b0, 8'h29, evts);
        check("rel_space_rows", 16'(kb.row_n), 16'h003F);

        // Overlapping shifts share one cell.
        kb.col_n = 16'hFEFF;
        key(1'b1, 1'b0, 8'h12, evts);
        check("lsh_evt", 16'(evts), 16'd1);
        check("lsh_rows", 16'(kb.row_n), 16'h001F);
        key(1'b1, 1'b0, 8'h59, evts);
        check("rsh_evt", 16'(evts), 16'd0);
        key(1'b0, 1'b0, 8'h12, evts);
        check("rel_lsh_evt", 16'(evts), 16'd0);
        check("rel_lsh_rows", 16'(kb.row_n), 16'h001F);
        key(1'b0, 1'b0, 8'h59, evts);
        check("rel_rsh_evt", 16'(evts), 16'd1);
        check("rel_rsh_rows", 16'(kb.row_n), 16'h003F);

        // Extended bit selects a different cell.
        kb.col_n = 16'hBFFF;
        key(1'b1, 1'b1, 8'h75, evts);
        check("crsr_up_rows", 16'(kb.row_n), 16'h003D);
        key(1'b1, 1'b0, 8'h75, evts);
        check("kp8_rows", 16'(kb.row_n), 16'h003C);
        key(1'b0, 1'b1, 8'h75, evts);
        key(1'b0, 1'b0, 8'h75, evts);
        check("col14_clear", 16'(kb.row_n), 16'h003F);

        // Unmapped code is a no-op.
        kb.col_n = 16'h0000;
        key(1'b1, 1'b0, 8'h07, evts);
        check("unmapped_evt", 16'(evts), 16'd0);
        check("unmapped_rows", 16'(kb.row_n), 16'h003F);

        // Back-to-back events on consecutive cycles.
        toggle_key(1'b1, 1'b0, 8'h1C);
        @(negedge clk);
        toggle_key(1'b1, 1'b0, 8'h29);
        wait_cyc(5, evts);
        check("b2b_evt", 16'(evts), 16'd2);
        check("b2b_rows", 16'(kb.row_n), 16'h001B);
        key(1'b0, 1'b0, 8'h29, evts);

        // release_all drops held keys and a same-cycle space press.
        key(1'b1, 1'b0, 8'h5A, evts);
        check("a_ret_rows", 16'(kb.row_n), 16'h0033);
        toggle_key(1'b1, 1'b0, 8'h29);
        kb.release_all = 1'b1;
        @(negedge clk);
        kb.release_all = 1'b0;
        wait_cyc(5, evts);
        check("rel_all_evt", 16'(evts), 16'd0);
        check("rel_all_rows", 16'(kb.row_n), 16'h003F);

        // Reset while an A press sits in stage 1.
        toggle_key(1'b1, 1'b0, 8'h1C);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_cyc(4, evts);
        check("rst_mid_evt", 16'(evts), 16'd0);
        check("rst_mid_rows", 16'(kb.row_n), 16'h003F);

        // Pipeline still works after the mid-flight reset.
        key(1'b1, 1'b0, 8'h29, evts);
        check("post_rst_evt", 16'(evts), 16'd1);
        check("post_rst_rows", 16'(kb.row_n), 16'h001F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
